// File: rtl/shift_sweep_ctrl.sv
// Drives the DAC shifter's shift_amt: a static shift value or a start->stop calibration
// sweep. Changes land only on frame_start and are flagged by a one-cycle shift_blank.
module shift_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [2:0]   cfg_addr,
    input  logic [15:0]  cfg_data,
    input  logic         frame_start,
    output logic [7:0]   shift_amt,
    output logic         shift_blank,
    output logic         sweep_busy,
    output logic         sweep_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_DWELL = 2'd2;

    logic [1:0]         r_state;
    logic               r_cfg_ready;
    logic [7:0]         r_static;
    logic [7:0]         r_start;
    logic [7:0]         r_stop;
    logic [7:0]         r_step;
    logic [DWELL_W-1:0] r_dwell;

    // Copies frozen at sweep start so host writes cannot disturb a running sweep
    logic [7:0]         r_sw_start;
    logic [7:0]         r_sw_stop;
    logic [7:0]         r_sw_step;
    logic [DWELL_W-1:0] r_sw_dwell;
    logic               r_sw_up;
    logic [DWELL_W-1:0] r_dwell_cnt;

    logic [7:0]         r_shift;
    logic               r_blank;
    logic               r_done;

    logic               w_wr;
    logic               w_ctrl_wr;
    logic               w_abort;
    logic               w_start;
    logic [7:0]         w_step_val;

    assign w_wr      = cfg_valid & r_cfg_ready;
    assign w_ctrl_wr = w_wr & (cfg_addr == 3'd5);
    assign w_abort   = w_ctrl_wr & cfg_data[1];
    assign w_start   = w_ctrl_wr & cfg_data[0] & ~cfg_data[1];

    // Clamp the last step to stop; both differences are non-negative in their direction
    always_comb begin
        w_step_val = r_shift;
        if (r_sw_up) begin
            if ((r_sw_stop - r_shift) < r_sw_step) w_step_val = r_sw_stop;
            else                                   w_step_val = r_shift + r_sw_step;
        end else begin
            if ((r_shift - r_sw_stop) < r_sw_step) w_step_val = r_sw_stop;
            else                                   w_step_val = r_shift - r_sw_step;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b0;
            r_static    <= 8'd0;
            r_start     <= 8'd0;
            r_stop      <= 8'd0;
            r_step      <= 8'd1;
            r_dwell     <= DWELL_W'(1);
            r_sw_start  <= 8'd0;
            r_sw_stop   <= 8'd0;
            r_sw_step   <= 8'd1;
            r_sw_dwell  <= DWELL_W'(1);
            r_sw_up     <= 1'b0;
            r_dwell_cnt <= '0;
            r_shift     <= 8'd0;
            r_blank     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cfg_ready <= 1'b1;
            r_blank     <= 1'b0;
            r_done      <= 1'b0;

            if (w_wr) begin
                case (cfg_addr)
                    3'd0:    r_static <= cfg_data[7:0];
                    3'd1:    r_start  <= cfg_data[7:0];
                    3'd2:    r_stop   <= cfg_data[7:0];
                    3'd3:    r_step   <= cfg_data[7:0];
                    3'd4:    r_dwell  <= cfg_data[DWELL_W-1:0];
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_shift <= r_static;
                        r_blank <= (r_static != r_shift);
                    end
                    if (w_start) begin
                        r_sw_start <= r_start;
                        r_sw_stop  <= r_stop;
                        r_sw_step  <= (r_step == 8'd0) ? 8'd1 : r_step;
                        r_sw_dwell <= (r_dwell == '0) ? DWELL_W'(1) : r_dwell;
                        r_sw_up    <= (r_stop > r_start);
                        r_state    <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (frame_start) begin
                        r_shift     <= r_sw_start;
                        r_blank     <= (r_sw_start != r_shift);
                        r_dwell_cnt <= r_sw_dwell - DWELL_W'(1);
                        r_state     <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (frame_start) begin
                        if (r_dwell_cnt != '0) begin
                            r_dwell_cnt <= r_dwell_cnt - DWELL_W'(1);
                        end else if (r_shift == r_sw_stop) begin
                            r_shift <= r_static;
                            r_blank <= (r_static != r_shift);
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_shift     <= w_step_val;
                            r_blank     <= (w_step_val != r_shift);
                            r_dwell_cnt <= r_sw_dwell - DWELL_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cfg_ready   = r_cfg_ready;
    assign shift_amt   = r_shift;
    assign shift_blank = r_blank;
    assign sweep_busy  = (r_state != ST_IDLE);
    assign sweep_done  = r_done;

endmodule

// File: doc/shift_sweep_ctrl.md
# shift_sweep_ctrl

Controller that owns the 8-bit `shift_amt` input of the DAC sample shifter. It applies a programmed static shift or runs an automatic calibration sweep (start → stop in fixed steps, holding each value for a programmed number of frames). Every change is committed only on a frame boundary, and each change is flagged so downstream capture logic can discard the affected frame. It sits between the host configuration bus and the shifter, in the DAC output clock domain.

## Interface
- `DWELL_W`, 16, width of the dwell (frames-per-step) register and counter.
- `clk`  in  1  DAC fabric clock; shared with the shifter.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  config write strobe.
- `cfg_ready`  out  1  config write accepted when `cfg_valid & cfg_ready`.
- `cfg_addr`  in  3  register address.
- `cfg_data`  in  16  write data.
- `frame_start`  in  1  single-cycle frame-boundary pulse.
- `shift_amt`  out  8  registered shift value driven to the shifter.
- `shift_blank`  out  1  one-cycle pulse, coincident with the first cycle of a changed `shift_amt`.
- `sweep_busy`  out  1  high while in ARM or DWELL.
- `sweep_done`  out  1  one-cycle pulse when a sweep completes normally.

## Operation
- Registers, all written on an accepted write. Unused data bits are ignored, and writes to addr 6–7 are ignored.
  - addr0 `static_shift[7:0]`
  - addr1 `sweep_start[7:0]`
  - addr2 `sweep_stop[7:0]`
  - addr3 `sweep_step[7:0]`; a value of 0 is treated as 1.
  - addr4 `dwell[DWELL_W-1:0]`; a value of 0 is treated as 1.
  - addr5 control: bit0 = start (self-clearing, not stored); bit1 = abort (self-clearing).
- Writes to addr1–4 during a sweep are stored but do not affect the running sweep. The running sweep uses copies latched on entry to ARM.
- States:
  - IDLE: on every `frame_start`, `shift_amt <= static_shift`. A control write with bit0=1 and bit1=0 latches start/stop/step/dwell and moves to ARM.
  - ARM: on the next `frame_start`, `shift_amt <= start`, `dwell_cnt <= dwell-1`, and the state moves to DWELL.
  - DWELL: on each `frame_start`:
    - If `dwell_cnt != 0`, decrement it.
    - Else if `shift_amt == stop`, set `shift_amt <= static_shift`, pulse `sweep_done`, and move to IDLE.
    - Else step toward `stop`: up if `stop > start`, down otherwise. If the remaining distance is less than the step, the new value is exactly `stop`; there is no overshoot and no 8-bit wrap. Reload `dwell_cnt <= dwell-1`.
- An abort write in ARM or DWELL returns to IDLE on the following cycle. `shift_amt` keeps its value until the next `frame_start`, which loads `static_shift`. No `sweep_done` is pulsed. A control write with both bits set acts as abort only.
- A start write while in ARM or DWELL is ignored.
- `start == stop` produces a single value held for `dwell` frames, then completion.

## Timing
- Reset values:
  - `shift_amt = 0`, `shift_blank = 0`, `sweep_busy = 0`, `sweep_done = 0`, `cfg_ready = 0`.
  - Registers: static 0, start 0, stop 0, step 1, dwell 1. State IDLE.
- `cfg_ready` is 1 on every cycle after reset deassertion. Writes take effect at the clock edge of acceptance.
- `shift_amt` updates at the edge where `frame_start` = 1 and is visible the next cycle. It never changes on any other cycle.
- `shift_blank` is high for exactly that first cycle, and only if the new value differs from the old.
- `sweep_done` is asserted in the same cycle that `shift_amt` returns to static. `sweep_busy` falls in the same cycle.
- A start write and `frame_start` in the same cycle: the state enters ARM at that edge. The same-cycle frame is not used, so the first sweep value is applied on the next `frame_start`.
- A `static_shift` write and `frame_start` in the same cycle (IDLE): the old `static_shift` is applied. The new value is applied on the following frame.
- Sweep length in frames = dwell × number of distinct values.
- Async reset mid-sweep forces all reset values immediately.

## Test plan
- Reset, then write addr0=37 and pulse `frame_start` → `shift_amt`=37 the next cycle, with `shift_blank` pulsing once. A second `frame_start` gives no blank.
- start=10, stop=30, step=8, dwell=2, start sweep, 9 frames → `shift_amt` sequence 10,10,18,18,26,26,30,30, then static. `sweep_done` is pulsed on the 9th frame; `sweep_busy` is high across frames 1–8.
- start=200, stop=190, step=0, dwell=0 → values 200,199,…,190 one frame each, then done.
- Abort during DWELL at value 18 → state IDLE the next cycle and `shift_amt` stays 18 until the next `frame_start`, then static. No `sweep_done`.
- Start write coincident with `frame_start` → no change on that frame; start value applied on the next frame. A start write during the sweep is ignored.
- Assert `rst` low mid-sweep → all outputs 0 immediately. After release, `cfg_ready`=1 and the state is IDLE.
